// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//   Plays a sequence of notes read from an external combinational note ROM.
//   Each ROM word is {end, dur[3:0], div[BW-1:0]}. A note lasts
//   (dur+1)*(tick_max+1) clocks and is rendered as a square wave of period
//   div clocks. A div of 0 or 1 is a rest. An optional silent gap of
//   GAP_CYCLES clocks follows every note.
//
// Ports
//   clk_i       : clock, all state changes on the rising edge
//   rst_ni      : asynchronous active-low reset, release synchronised inside
//   start_i     : one-cycle pulse, starts playback at address 0 (IDLE only)
//   stop_i      : aborts playback, returns to IDLE (wins over start_i)
//   loop_i      : restart at address 0 after the end note instead of stopping
//   tick_max_i  : tempo tick period minus 1, captured at every LOAD
//   rom_addr_o  : note address to the external ROM
//   rom_data_i  : ROM word for rom_addr_o, same cycle
//   sound_o     : registered square-wave output
//   busy_o      : high whenever the sequencer is not IDLE
//   done_o      : one-cycle pulse when a non-looping sequence completes
// -----------------------------------------------------------------------------
module tone_sequencer #(
  parameter int BW         = 16,
  parameter int AW         = 6,
  parameter int TICK_BW    = 24,
  parameter int GAP_CYCLES = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               loop_i,
  input  logic [TICK_BW-1:0] tick_max_i,
  output logic [AW-1:0]      rom_addr_o,
  input  logic [BW+4:0]      rom_data_i,
  output logic               sound_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Gap counter runs 0..GAP_CYCLES-1; keep at least one bit when unused.
  localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  // NOTE: reset asserts asynchronously but releases only after two clock
  // edges, so no flop leaves reset on an edge that races the release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [BW-1:0]      div_q, div_d;
  logic [BW-1:0]      pwm_q, pwm_d;
  logic [3:0]         dur_q, note_q;
  logic               end_q;
  logic [TICK_BW-1:0] tick_max_q, tick_q;
  logic [GW-1:0]      gap_q;
  logic               sound_q, sound_d;
  logic               done_q, done_d;

  logic tick_strobe, note_end, gap_last, decide, seq_last;

  // Status decode shared by the next-state and output logic.
  always_comb begin
    tick_strobe = (state_q == PLAY) && (tick_q == tick_max_q);
    note_end    = tick_strobe && (note_q == dur_q);
    gap_last    = (state_q == GAP) && (gap_q == GAP_LAST);
    // Next-note decision: straight from the note end, or after the gap.
    decide      = (GAP_CYCLES == 0) ? note_end : gap_last;
    seq_last    = end_q || (addr_q == {AW{1'b1}});
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: state_d = PLAY;
      PLAY: begin
        if (decide)        state_d = (seq_last && !loop_i) ? IDLE : LOAD;
        else if (note_end) state_d = GAP;
      end
      GAP:  if (decide)    state_d = (seq_last && !loop_i) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
    if (stop_i) state_d = IDLE;
  end

  // Output and datapath next values.
  always_comb begin
    busy_o = (state_q != IDLE);
    done_d = decide && seq_last && !loop_i && !stop_i;

    addr_d = addr_q;
    if (stop_i || (state_q == IDLE && start_i)) addr_d = '0;
    else if (decide)                            addr_d = seq_last ? '0 : addr_q + AW'(1);

    div_d = (state_q == LOAD) ? rom_data_i[BW-1:0] : div_q;

    pwm_d = pwm_q;
    if (state_q == LOAD) begin
      pwm_d = '0;
    end else if (state_q == PLAY) begin
      // Rests (div 0/1) hold the counter at 0 instead of wrapping below zero.
      if (div_q <= BW'(1) || pwm_q == div_q - BW'(1)) pwm_d = '0;
      else                                             pwm_d = pwm_q + BW'(1);
    end

    // Computed from next-cycle values so sound_o is aligned with PLAY cycles
    // and is low in every other state. div>>1 is 0 for a rest.
    sound_d = (state_d == PLAY) && (pwm_d < (div_d >> 1));
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      div_q      <= '0;
      pwm_q      <= '0;
      dur_q      <= '0;
      note_q     <= '0;
      end_q      <= 1'b0;
      tick_max_q <= '0;
      tick_q     <= '0;
      gap_q      <= '0;
      sound_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      div_q   <= div_d;
      pwm_q   <= pwm_d;
      sound_q <= sound_d;
      done_q  <= done_d;
      if (state_q == LOAD) begin
        dur_q      <= rom_data_i[BW+3:BW];
        end_q      <= rom_data_i[BW+4];
        tick_max_q <= tick_max_i;
        tick_q     <= '0;
        note_q     <= '0;
      end else if (state_q == PLAY) begin
        tick_q <= tick_strobe ? '0 : tick_q + TICK_BW'(1);
        // Hold on the final strobe so the note counter never passes dur.
        if (tick_strobe && !note_end) note_q <= note_q + 4'd1;
        if (note_end)                 gap_q  <= '0;
      end else if (state_q == GAP) begin
        gap_q <= gap_q + GW'(1);
      end
    end
  end

  assign rom_addr_o = addr_q;
  assign sound_o    = sound_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tone_sequencer
//   Self-checking bench for tone_sequencer. Three instances are used: default
//   parameters, GAP_CYCLES=3, and AW=2. Expected per-cycle outputs are
//   generated from the note list (LOAD cycle, note body, gap, done pulse) and
//   compared cycle by cycle against the selected instance.
// -----------------------------------------------------------------------------
module tb_tone_sequencer;

  localparam int BW  = 16;
  localparam int WW  = BW + 5;
  localparam int TBW = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]     start;
  logic           stop;
  logic           loop_en;
  logic [TBW-1:0] tick_max;
  logic [WW-1:0]  rom [3][64];

  logic [5:0] addr0, addr1, addr2x;
  logic [1:0] addr2;
  logic       snd0, snd1, snd2;
  logic       bsy0, bsy1, bsy2;
  logic       dn0, dn1, dn2;

  assign addr2x = {4'd0, addr2};

  tone_sequencer #(.BW(BW), .AW(6), .TICK_BW(TBW), .GAP_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .stop_i(stop),
    .loop_i(loop_en), .tick_max_i(tick_max), .rom_addr_o(addr0),
    .rom_data_i(rom[0][addr0]), .sound_o(snd0), .busy_o(bsy0), .done_o(dn0));

  tone_sequencer #(.BW(BW), .AW(6), .TICK_BW(TBW), .GAP_CYCLES(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .stop_i(stop),
    .loop_i(loop_en), .tick_max_i(tick_max), .rom_addr_o(addr1),
    .rom_data_i(rom[1][addr1]), .sound_o(snd1), .busy_o(bsy1), .done_o(dn1));

  tone_sequencer #(.BW(BW), .AW(2), .TICK_BW(TBW), .GAP_CYCLES(0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .stop_i(stop),
    .loop_i(loop_en), .tick_max_i(tick_max), .rom_addr_o(addr2),
    .rom_data_i(rom[2][addr2x]), .sound_o(snd2), .busy_o(bsy2), .done_o(dn2));

  typedef struct {
    logic sound;
    logic busy;
    logic done;
    int   addr;
    bit   is_load;
    int   tm;        // tick_max to present during a LOAD cycle
    int   loop_req;  // loop_i required at a next-note decision, -1 = free
  } exp_t;

  exp_t exp_q[$];
  int   tm_arr[64];
  int   total = 0;
  int   bad   = 0;

  function automatic void get_out(input int w, output logic s, output logic b,
                                  output logic d, output int a);
    case (w)
      0:       begin s = snd0; b = bsy0; d = dn0; a = int'(addr0);  end
      1:       begin s = snd1; b = bsy1; d = dn1; a = int'(addr1);  end
      default: begin s = snd2; b = bsy2; d = dn2; a = int'(addr2x); end
    endcase
  endfunction

  task automatic push_rec(input logic s, input logic b, input logic d, input int a,
                          input bit ld, input int tm, input int lr);
    exp_t r;
    r.sound = s; r.busy = b; r.done = d; r.addr = a;
    r.is_load = ld; r.tm = tm; r.loop_req = lr;
    exp_q.push_back(r);
  endtask

  // Expected trace for a run starting from the cycle after the start pulse.
  task automatic build(input int w, input int gap, input int depth, input int passes);
    int            note_i, a, dv, du, len;
    logic [WW-1:0] word;
    bit            last, hi;
    exp_q.delete();
    note_i = 0;
    for (int p = 0; p < passes; p++) begin
      a    = 0;
      last = 1'b0;
      while (!last) begin
        word = rom[w][a];
        dv   = int'(word[15:0]);
        du   = int'(word[19:16]);
        last = word[20] || (a == depth - 1);
        push_rec(1'b0, 1'b1, 1'b0, a, 1'b1, tm_arr[note_i], -1);
        len = (du + 1) * (tm_arr[note_i] + 1);
        for (int k = 0; k < len; k++) begin
          hi = 1'b0;
          if (dv >= 2) hi = ((k % dv) < (dv / 2));
          push_rec(hi, 1'b1, 1'b0, a, 1'b0, 0, -1);
        end
        for (int g = 0; g < gap; g++) push_rec(1'b0, 1'b1, 1'b0, a, 1'b0, 0, -1);
        if (last) exp_q[exp_q.size()-1].loop_req = (p < passes - 1) ? 1 : 0;
        note_i++;
        a++;
      end
    end
    push_rec(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, -1);
    push_rec(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, -1);
    push_rec(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, -1);
  endtask

  task automatic rand_rom(input int w, input int depth, input int nnotes);
    for (int a = 0; a < 64; a++) begin
      if (a < depth)
        rom[w][a] = {1'(a == nnotes - 1), 4'($urandom_range(0, 3)), 16'($urandom_range(0, 12))};
      else
        rom[w][a] = '0;
    end
  endtask

  task automatic rand_tm(input int maxv);
    for (int i = 0; i < 64; i++) tm_arr[i] = $urandom_range(0, maxv);
  endtask

  // Runs the expected trace against instance w. abort kinds: 0 none,
  // 1 stop, 2 stop+start together, 3 asynchronous reset between edges.
  task automatic play(input int w, input string name, input int abort_at,
                      input int kind, input bit noise);
    logic s, b, d;
    int   a;
    exp_t e;
    @(negedge clk);
    stop     = 1'b0;
    start    = '0;
    start[w] = 1'b1;
    tick_max = TBW'($urandom_range(0, 50));
    @(negedge clk);
    start[w] = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      get_out(w, s, b, d, a);
      total++;
      if ({s, b, d} !== {e.sound, e.busy, e.done} || a != e.addr) begin
        bad++;
        $display("FAIL %s cycle %0d sound/busy/done/addr got %b%b%b/%0d want %b%b%b/%0d",
                 name, i, s, b, d, a, e.sound, e.busy, e.done, e.addr);
      end
      if (i == abort_at) begin
        if (kind == 3) begin
          #2 rst_n = 1'b0;
          #1 get_out(w, s, b, d, a);
          total++;
          if ({s, b, d} !== 3'b000 || a != 0) begin
            bad++;
            $display("FAIL %s async reset got %b%b%b/%0d want 000/0", name, s, b, d, a);
          end
          @(negedge clk);
          rst_n = 1'b1;
        end else begin
          stop     = 1'b1;
          start[w] = (kind == 2);
          @(negedge clk);
          stop     = 1'b0;
          start[w] = 1'b0;
        end
        for (int j = 0; j < 5; j++) begin
          get_out(w, s, b, d, a);
          total++;
          if ({s, b, d} !== 3'b000 || a != 0) begin
            bad++;
            $display("FAIL %s after abort +%0d got %b%b%b/%0d want 000/0", name, j, s, b, d, a);
          end
          @(negedge clk);
        end
        return;
      end
      tick_max = e.is_load ? TBW'(e.tm) : TBW'($urandom_range(0, 50));
      loop_en  = (e.loop_req >= 0) ? e.loop_req[0] : 1'($urandom_range(0, 1));
      start[w] = noise && e.busy && ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    start[w] = 1'b0;
  endtask

  task automatic test_reset();
    logic s, b, d;
    int   a;
    #1 rst_n = 1'b0;
    #2;
    for (int w = 0; w < 3; w++) begin
      get_out(w, s, b, d, a);
      total++;
      if ({s, b, d} !== 3'b000 || a != 0) begin
        bad++;
        $display("FAIL reset dut%0d got %b%b%b/%0d want 000/0", w, s, b, d, a);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      get_out(0, s, b, d, a);
      total++;
      if ({s, b, d} !== 3'b000 || a != 0) begin
        bad++;
        $display("FAIL reset_release got %b%b%b/%0d want 000/0", s, b, d, a);
      end
    end
  endtask

  task automatic load_demo(input int w);
    for (int a = 0; a < 64; a++) rom[w][a] = '0;
    rom[w][0] = {1'b0, 4'd1, 16'd8};
    rom[w][1] = {1'b0, 4'd0, 16'd0};
    rom[w][2] = {1'b1, 4'd0, 16'd4};
  endtask

  task automatic test_tone_rest_end();
    load_demo(0);
    for (int i = 0; i < 64; i++) tm_arr[i] = 9;
    build(0, 0, 64, 1);
    play(0, "tone_rest_end", -1, 0, 1'b0);
  endtask

  task automatic test_loop();
    load_demo(0);
    for (int i = 0; i < 64; i++) tm_arr[i] = 9;
    build(0, 0, 64, 3);
    play(0, "loop", -1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      rand_rom(0, 64, $urandom_range(1, 5));
      rand_tm(3);
      build(0, 0, 64, $urandom_range(1, 3));
      play(0, "random", -1, 0, 1'b1);
    end
  endtask

  task automatic test_gap();
    load_demo(1);
    for (int i = 0; i < 64; i++) tm_arr[i] = 1;
    build(1, 3, 64, 1);
    play(1, "gap_demo", -1, 0, 1'b0);
    for (int it = 0; it < 3; it++) begin
      rand_rom(1, 64, $urandom_range(1, 4));
      rand_tm(2);
      build(1, 3, 64, $urandom_range(1, 2));
      play(1, "gap_random", -1, 0, 1'b1);
    end
  endtask

  task automatic test_aw2_wrap();
    rand_rom(2, 4, 99);
    for (int i = 0; i < 64; i++) tm_arr[i] = 0;
    build(2, 0, 4, 1);
    play(2, "aw2_end", -1, 0, 1'b0);
    rand_rom(2, 4, 99);
    build(2, 0, 4, 2);
    play(2, "aw2_loop", -1, 0, 1'b1);
  endtask

  task automatic test_stop();
    logic s, b, d;
    int   a;
    for (int kind = 1; kind <= 2; kind++) begin
      rand_rom(0, 64, $urandom_range(2, 4));
      rand_tm(3);
      build(0, 0, 64, 1);
      play(0, (kind == 1) ? "stop" : "stop_start", $urandom_range(1, exp_q.size() - 4), kind, 1'b1);
    end
    // start and stop together while idle: stop wins, nothing starts.
    @(negedge clk);
    start[0] = 1'b1;
    stop     = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    stop     = 1'b0;
    repeat (2) begin
      get_out(0, s, b, d, a);
      total++;
      if ({s, b, d} !== 3'b000 || a != 0) begin
        bad++;
        $display("FAIL idle_stop_start got %b%b%b/%0d want 000/0", s, b, d, a);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_play();
    rand_rom(0, 64, 3);
    rand_tm(3);
    build(0, 0, 64, 1);
    play(0, "reset_mid_play", $urandom_range(2, exp_q.size() - 4), 3, 1'b0);
    rand_rom(0, 64, 2);
    rand_tm(2);
    build(0, 0, 64, 1);
    play(0, "after_reset", -1, 0, 1'b0);
  endtask

  initial begin
    start    = '0;
    stop     = 1'b0;
    loop_en  = 1'b0;
    tick_max = '0;
    for (int w = 0; w < 3; w++)
      for (int a = 0; a < 64; a++) rom[w][a] = '0;
    test_reset();
    test_tone_rest_end();
    test_loop();
    test_random();
    test_gap();
    test_aw2_wrap();
    test_stop();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter BW, default 16: width of the note divider field and of the PWM counter.
REQ-002 Parameter AW, default 6: width of the sequence address; sequence depth 2^AW.
REQ-003 Parameter TICK_BW, default 24: width of the tempo tick counter.
REQ-004 Parameter GAP_CYCLES, default 0: number of silent clocks inserted after every note; 0 means no gap.
REQ-005 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 start_i  input  1  one-cycle pulse that starts playback from address 0.
REQ-008 stop_i  input  1  aborts playback.
REQ-009 loop_i  input  1  when set, the sequence restarts at address 0 after its end note.
REQ-010 tick_max_i  input  TICK_BW  tempo tick period minus 1, in clocks.
REQ-011 rom_addr_o  output  AW  note address presented to the external combinational note ROM.
REQ-012 rom_data_i  input  BW+5  ROM word {end[BW+4], dur[BW+3:BW], div[BW-1:0]}, valid in the same cycle as rom_addr_o.
REQ-013 sound_o  output  1  registered square-wave audio output.
REQ-014 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-015 done_o  output  1  one-cycle pulse when a non-looping sequence completes.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, PLAY and GAP.
REQ-017 In IDLE, start_i SHALL set rom_addr_o to 0 and move the FSM to LOAD on the next edge.
REQ-018 LOAD SHALL last exactly 1 cycle; it SHALL latch div, dur, end and tick_max_i, clear the tick, note and PWM counters, and enter PLAY.
REQ-019 Tick counter (PLAY only): counts 0..latched tick_max; a strobe is raised in the cycle it equals tick_max, then it wraps to 0; tick_max=0 gives a strobe every cycle.
REQ-020 Each strobe SHALL increment the note counter; the note ends on the strobe where the note counter equals dur, so a note lasts (dur+1)*(tick_max+1) clocks.
REQ-021 At note end: if GAP_CYCLES>0, go to GAP for exactly GAP_CYCLES clocks; otherwise take the next-note decision directly.
REQ-022 Next-note decision (end=1 or rom_addr_o=2^AW-1): if loop_i=1, set the address to 0 and go to LOAD; else pulse done_o, go to IDLE, and set the address to 0.
REQ-023 Next-note decision (neither condition true): increment the address by 1 and go to LOAD.
REQ-024 PWM (PLAY only): counter runs 0..div-1 and wraps; sound_o = 1 while counter < (div>>1), else 0.
REQ-025 div of 0 or 1 SHALL be a rest: sound_o stays 0 for the whole note, while timing still advances.
REQ-026 sound_o SHALL be 0 in IDLE, LOAD and GAP.
REQ-027 stop_i in any state SHALL force IDLE on the next edge, with address 0, sound_o 0 and no done_o.
REQ-028 When stop_i and start_i are high together, stop_i SHALL win.
REQ-029 start_i SHALL be ignored while busy_o=1.
REQ-030 loop_i SHALL be sampled only at the next-note decision.
REQ-031 Changes on tick_max_i SHALL take effect only at the next LOAD.
REQ-032 All counters SHALL be sized to their parameters and SHALL NOT overflow for any legal input.

Reset
REQ-033 Asserting rst_ni low SHALL immediately force state IDLE, all counters 0, rom_addr_o=0, sound_o=0, busy_o=0 and done_o=0, independent of clk_i.
REQ-034 Reset release SHALL be synchronised internally so that the first active edge after release sees IDLE; reset mid-PLAY discards the current note.

Verification
REQ-035 Sequence tone/rest/end: ROM[0]={0,1,8}, ROM[1]={0,0,0}, ROM[2]={1,0,4}, tick_max=9, loop=0, start pulse.
  -> busy_o rises 1 clock after start.
  -> Note 0: sound_o period 8 (4 high / 4 low) for 20 clocks.
  -> Note 1: sound_o low for 10 clocks.
  -> Note 2: period 4 for 10 clocks.
  -> LOAD cycles are silent; done_o pulses once, then IDLE.
REQ-036 Same ROM with loop=1 -> after ROM[2], rom_addr_o returns to 0 with no done_o; loop is cleared mid-run -> done_o fires after the following ROM[2].
REQ-037 GAP_CYCLES=3 -> exactly 3 silent clocks between each note end and the next LOAD.
REQ-038 stop_i mid-note, and stop_i+start_i in the same cycle -> IDLE next edge, sound_o=0, no done_o; a start_i pulse during PLAY has no effect.
REQ-039 AW=2 with no end flag anywhere -> the sequence ends after address 3; tick_max=0 -> each note lasts dur+1 clocks.
REQ-040 rst_ni asserted between clock edges mid-PLAY -> outputs go to reset values immediately; after release, the block waits in IDLE for start_i.
